// File: rtl/vx_cache_flush_seq_pkg.sv
// Geometry helpers for the per-bank flush/init sequencer.
package vx_cache_flush_seq_pkg;

  function automatic int up(input int x);
    return (x > 0) ? x : 1;
  endfunction

  function automatic int lines_per_bank(input int cs, input int ls, input int nb, input int nw);
    return cs / (ls * nb * nw);
  endfunction

  function automatic int line_sel_bits(input int cs, input int ls, input int nb, input int nw);
    return up($clog2(lines_per_bank(cs, ls, nb, nw)));
  endfunction

endpackage

// File: rtl/vx_cache_flush_seq_decoder.sv
// Binary-to-one-hot decoder for the way select; all zeros when disabled.
module vx_cache_flush_seq_decoder #(
  parameter int N  = 1,
  parameter int SW = 1
) (
  input  logic [SW-1:0] sel,
  input  logic          en,
  output logic [N-1:0]  onehot
);

  for (genvar gi = 0; gi < N; gi++) begin : g_dec
    assign onehot[gi] = en && (sel == SW'(gi));
  end

endmodule

// File: rtl/vx_cache_flush_seq.sv
// Per-bank maintenance sequencer: reset-time init walk over all lines and
// on-demand flush of every (line, way), with drain and completion pulse.
module vx_cache_flush_seq
  import vx_cache_flush_seq_pkg::*;
#(
  parameter int CACHE_SIZE  = 1024,
  parameter int LINE_SIZE   = 16,
  parameter int NUM_BANKS   = 1,
  parameter int NUM_WAYS    = 1,
  parameter     INSTANCE_ID = ""
) (
  input  logic clk,
  input  logic reset,
  input  logic flush_begin,
  output logic flush_end,
  output logic init_busy,
  input  logic mshr_empty,
  input  logic pipe_empty,
  output logic seq_valid,
  input  logic seq_ready,
  output logic seq_init,
  output logic seq_flush,
  output logic [line_sel_bits(CACHE_SIZE, LINE_SIZE, NUM_BANKS, NUM_WAYS)-1:0] seq_line_sel,
  output logic [NUM_WAYS-1:0] seq_way_sel
);

  localparam int L     = lines_per_bank(CACHE_SIZE, LINE_SIZE, NUM_BANKS, NUM_WAYS);
  localparam int W     = NUM_WAYS;
  localparam int LB    = $clog2(L);
  localparam int WB    = $clog2(W);
  localparam int LSW   = line_sel_bits(CACHE_SIZE, LINE_SIZE, NUM_BANKS, NUM_WAYS);
  localparam int WSW   = up(WB);
  localparam int CNT_W = up(LB + WB);

  localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(L - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(L * W - 1);
  localparam logic [CNT_W-1:0] WAY_MASK   = CNT_W'(W - 1);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WAIT,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pending_reg, pending_next;

  logic             fire;
  logic [WSW-1:0]   way_field;
  logic [W-1:0]     way_onehot;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= ST_INIT;
      cnt_reg     <= '0;
      pending_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pending_reg <= pending_next;
    end
  end

  // Reset gates the valid so no operation leaks out while the bank is held.
  assign seq_valid = !reset && ((state_reg == ST_INIT) || (state_reg == ST_FLUSH));
  assign seq_init  = seq_valid && (state_reg == ST_INIT);
  assign seq_flush = seq_valid && (state_reg == ST_FLUSH);
  assign init_busy = (state_reg == ST_INIT);
  assign flush_end = (state_reg == ST_DONE);
  assign fire      = seq_valid && seq_ready;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    pending_next = pending_reg;
    case (state_reg)
      ST_INIT: begin
        if (flush_begin) pending_next = 1'b1;
        if (fire) begin
          if (cnt_reg == INIT_LAST) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      ST_IDLE: begin
        if (flush_begin || pending_reg) begin
          state_next   = ST_WAIT;
          pending_next = 1'b0;
        end
      end
      ST_WAIT: begin
        if (mshr_empty) begin
          state_next = ST_FLUSH;
          cnt_next   = '0;
        end
      end
      ST_FLUSH: begin
        if (fire) begin
          if (cnt_reg == FLUSH_LAST) begin
            state_next = ST_DRAIN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (pipe_empty) state_next = ST_DONE;
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_INIT;
        cnt_next   = '0;
      end
    endcase
  end

  // Flush counter is {line, way} with way in the low bits.
  assign way_field = WSW'(cnt_reg & WAY_MASK);

  vx_cache_flush_seq_decoder #(
    .N  (W),
    .SW (WSW)
  ) u_way_dec (
    .sel    (way_field),
    .en     (seq_flush),
    .onehot (way_onehot)
  );

  always_comb begin
    seq_line_sel = '0;
    seq_way_sel  = '0;
    if (seq_init) begin
      seq_line_sel = LSW'(cnt_reg);
      seq_way_sel  = '1;
    end else if (seq_flush) begin
      seq_line_sel = LSW'(cnt_reg >> WB);
      seq_way_sel  = way_onehot;
    end
  end

endmodule

// File: tb/tb_vx_cache_flush_seq.sv
// Self-checking bench for vx_cache_flush_seq: 256B cache, 16B lines, 2 ways (8 lines).
module tb_vx_cache_flush_seq;

  localparam int CS  = 256;
  localparam int LS  = 16;
  localparam int NB  = 1;
  localparam int NW  = 2;
  localparam int L   = CS / (LS * NB * NW);
  localparam int W   = NW;
  localparam int LSW = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           flush_begin = 1'b0;
  logic           mshr_empty = 1'b1;
  logic           pipe_empty = 1'b1;
  logic           seq_ready = 1'b1;
  logic           flush_end;
  logic           init_busy;
  logic           seq_valid;
  logic           seq_init;
  logic           seq_flush;
  logic [LSW-1:0] seq_line_sel;
  logic [W-1:0]   seq_way_sel;

  vx_cache_flush_seq #(
    .CACHE_SIZE  (CS),
    .LINE_SIZE   (LS),
    .NUM_BANKS   (NB),
    .NUM_WAYS    (NW),
    .INSTANCE_ID ("tb")
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush_begin  (flush_begin),
    .flush_end    (flush_end),
    .init_busy    (init_busy),
    .mshr_empty   (mshr_empty),
    .pipe_empty   (pipe_empty),
    .seq_valid    (seq_valid),
    .seq_ready    (seq_ready),
    .seq_init     (seq_init),
    .seq_flush    (seq_flush),
    .seq_line_sel (seq_line_sel),
    .seq_way_sel  (seq_way_sel)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_init;
    bit is_flush;
    int line;
    int way;
    int cyc;
  } op_t;

  op_t obs_q[$];
  op_t exp_q[$];
  int  fe_q[$];
  op_t rec;
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive recorder: every accepted operation and every flush_end cycle.
  always @(negedge clk) begin
    if (seq_valid && seq_ready) begin
      rec.is_init  = seq_init;
      rec.is_flush = seq_flush;
      rec.line     = int'(seq_line_sel);
      rec.way      = int'(seq_way_sel);
      rec.cyc      = cyc;
      obs_q.push_back(rec);
    end
    if (flush_end === 1'b1) fe_q.push_back(cyc);
  end

  // Reference model: an init touches every line on all ways; a flush visits
  // each line, way by way. start < 0 means the timing is not fixed.
  task automatic model_init(input int start);
    op_t o;
    for (int l = 0; l < L; l++) begin
      o.is_init = 1; o.is_flush = 0; o.line = l; o.way = (1 << W) - 1;
      o.cyc = (start < 0) ? -1 : start + l;
      exp_q.push_back(o);
    end
  endtask

  task automatic model_flush(input int start, input int count);
    op_t o;
    int  n;
    n = 0;
    for (int l = 0; l < L; l++) begin
      for (int w = 0; w < W; w++) begin
        if (n < count) begin
          o.is_init = 0; o.is_flush = 1; o.line = l; o.way = 1 << w;
          o.cyc = (start < 0) ? -1 : start + n;
          exp_q.push_back(o);
        end
        n++;
      end
    end
  endtask

  task automatic clear_all();
    obs_q.delete();
    exp_q.delete();
    fe_q.delete();
  endtask

  task automatic test_reset();
    logic [3+LSW+W-1:0] got, want;
    clear_all();
    seq_ready = 1; flush_begin = 0; reset = 1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (seq_valid !== 1'b0 || seq_init !== 1'b0 || seq_flush !== 1'b0 || init_busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold: valid=%b init=%b flush=%b busy=%b want 0 0 0 1",
               seq_valid, seq_init, seq_flush, init_busy);
    end
    @(posedge clk); #1;
    reset = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      want = (k <= L) ? {3'b110, LSW'(k - 1), {W{1'b1}}} : '0;
      got  = {seq_valid, seq_init, seq_flush, seq_line_sel, seq_way_sel};
      checks++;
      if (got !== want || init_busy !== (k <= L)) begin
        errors++;
        $display("FAIL init_walk cycle %0d: got=%h busy=%b want=%h busy=%b",
                 k, got, init_busy, want, (k <= L));
      end
      @(posedge clk); #1;
    end
    model_init(-1);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL init_count: got %0d ops want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].is_init != exp_q[i].is_init || obs_q[i].line != exp_q[i].line ||
          obs_q[i].way != exp_q[i].way) begin
        errors++;
        $display("FAIL init_op %0d: got init=%0d line=%0d way=%0d want init=%0d line=%0d way=%0d",
                 i, obs_q[i].is_init, obs_q[i].line, obs_q[i].way,
                 exp_q[i].is_init, exp_q[i].line, exp_q[i].way);
      end
    end
    $display("test_reset: %0d init ops observed", obs_q.size());
  endtask

  task automatic test_flush_basic();
    int base, got_fe;
    clear_all();
    mshr_empty = 1; pipe_empty = 1; seq_ready = 1;
    @(posedge clk); #1;
    flush_begin = 1; base = cyc;
    @(posedge clk); #1;
    flush_begin = 0;
    for (int i = 0; i < 100 && fe_q.size() == 0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    model_flush(base + 2, L * W);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL flush_count: got %0d ops want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].is_flush != 1 || obs_q[i].is_init != 0 || obs_q[i].line != exp_q[i].line ||
          obs_q[i].way != exp_q[i].way || obs_q[i].cyc != exp_q[i].cyc) begin
        errors++;
        $display("FAIL flush_op %0d: got line=%0d way=%0d cyc=%0d want line=%0d way=%0d cyc=%0d",
                 i, obs_q[i].line, obs_q[i].way, obs_q[i].cyc - base,
                 exp_q[i].line, exp_q[i].way, exp_q[i].cyc - base);
      end
    end
    got_fe = (fe_q.size() > 0) ? fe_q[0] - base : -1;
    checks++;
    if (fe_q.size() != 1 || got_fe != 3 + L * W) begin
      errors++;
      $display("FAIL flush_end_time: got %0d pulses at cycle %0d want 1 at %0d",
               fe_q.size(), got_fe, 3 + L * W);
    end
    $display("test_flush_basic: %0d flush ops, flush_end at cycle %0d", obs_q.size(), got_fe);
  endtask

  task automatic test_backpressure();
    int  base;
    bit  prev_stall;
    logic [2+LSW+W-1:0] prev_out, cur_out;
    clear_all();
    mshr_empty = 0; pipe_empty = 1; seq_ready = 1;
    @(posedge clk); #1;
    flush_begin = 1; base = cyc;
    @(posedge clk); #1;
    flush_begin = 0;
    for (int k = 1; k <= 5; k++) begin
      seq_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (seq_valid !== 1'b0) begin
        errors++;
        $display("FAIL wait_no_op cycle %0d: seq_valid=%b want 0", k, seq_valid);
      end
      @(posedge clk); #1;
    end
    mshr_empty = 1;
    prev_stall = 0;
    prev_out = '0;
    for (int i = 0; i < 400 && fe_q.size() == 0; i++) begin
      seq_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      cur_out = {seq_valid, seq_flush, seq_line_sel, seq_way_sel};
      if (prev_stall) begin
        checks++;
        if (cur_out !== prev_out) begin
          errors++;
          $display("FAIL stall_stable: got %h want %h", cur_out, prev_out);
        end
      end
      prev_stall = seq_valid && !seq_ready;
      prev_out = cur_out;
      @(posedge clk); #1;
    end
    seq_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    model_flush(-1, L * W);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bp_count: got %0d ops want %0d", obs_q.size(), exp_q.size());
    end
    checks++;
    if (obs_q.size() > 0 && obs_q[0].cyc - base < 7) begin
      errors++;
      $display("FAIL bp_first_op: got cycle %0d want >= 7", obs_q[0].cyc - base);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].is_flush != 1 || obs_q[i].line != exp_q[i].line || obs_q[i].way != exp_q[i].way) begin
        errors++;
        $display("FAIL bp_op %0d: got line=%0d way=%0d want line=%0d way=%0d",
                 i, obs_q[i].line, obs_q[i].way, exp_q[i].line, exp_q[i].way);
      end
    end
    checks++;
    if (fe_q.size() != 1) begin
      errors++;
      $display("FAIL bp_flush_end: got %0d pulses want 1", fe_q.size());
    end
    $display("test_backpressure: %0d flush ops under random ready", obs_q.size());
  endtask

  task automatic test_pending();
    int r0, got_fe;
    clear_all();
    mshr_empty = 1; pipe_empty = 1; seq_ready = 1;
    reset = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 0; r0 = cyc;
    for (int k = 1; k <= 40; k++) begin
      flush_begin = (k == 3 || k == 15);
      @(posedge clk); #1;
    end
    flush_begin = 0;
    // 8 inits, then IDLE and WAIT each take one cycle before the flush.
    model_init(r0);
    model_flush(r0 + L + 2, L * W);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL pending_count: got %0d ops want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].is_init != exp_q[i].is_init || obs_q[i].is_flush != exp_q[i].is_flush ||
          obs_q[i].line != exp_q[i].line || obs_q[i].way != exp_q[i].way ||
          obs_q[i].cyc != exp_q[i].cyc) begin
        errors++;
        $display("FAIL pending_op %0d: got i=%0d f=%0d line=%0d way=%0d cyc=%0d want i=%0d f=%0d line=%0d way=%0d cyc=%0d",
                 i, obs_q[i].is_init, obs_q[i].is_flush, obs_q[i].line, obs_q[i].way,
                 obs_q[i].cyc - r0, exp_q[i].is_init, exp_q[i].is_flush, exp_q[i].line,
                 exp_q[i].way, exp_q[i].cyc - r0);
      end
    end
    got_fe = (fe_q.size() > 0) ? fe_q[0] - r0 : -1;
    checks++;
    if (fe_q.size() != 1 || got_fe != L + 3 + L * W) begin
      errors++;
      $display("FAIL pending_flush_end: got %0d pulses at %0d want 1 at %0d",
               fe_q.size(), got_fe, L + 3 + L * W);
    end
    $display("test_pending: %0d ops, flush_end at cycle %0d", obs_q.size(), got_fe);
  endtask

  task automatic test_drain();
    int base, got_fe;
    clear_all();
    mshr_empty = 1; pipe_empty = 0; seq_ready = 1;
    @(posedge clk); #1;
    flush_begin = 1; base = cyc;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      flush_begin = 0;
      pipe_empty = (k >= L * W + 6);
    end
    pipe_empty = 1;
    got_fe = (fe_q.size() > 0) ? fe_q[0] - base : -1;
    checks++;
    if (fe_q.size() != 1 || got_fe != 3 + L * W + 4) begin
      errors++;
      $display("FAIL drain_flush_end: got %0d pulses at %0d want 1 at %0d",
               fe_q.size(), got_fe, 3 + L * W + 4);
    end
    checks++;
    if (obs_q.size() != L * W) begin
      errors++;
      $display("FAIL drain_count: got %0d ops want %0d", obs_q.size(), L * W);
    end
    $display("test_drain: flush_end at cycle %0d", got_fe);
  endtask

  task automatic test_reset_mid_flush();
    int base;
    logic [3+LSW+W-1:0] got, want;
    clear_all();
    mshr_empty = 1; pipe_empty = 1; seq_ready = 1;
    @(posedge clk); #1;
    flush_begin = 1; base = cyc;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      flush_begin = 0;
      reset = (k == 6);
    end
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    want = {3'b110, LSW'(0), {W{1'b1}}};
    got  = {seq_valid, seq_init, seq_flush, seq_line_sel, seq_way_sel};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_mid_restart: got %h want %h", got, want);
    end
    repeat (40) @(posedge clk);
    #1;
    model_flush(base + 2, 4);
    model_init(base + 7);
    checks++;
    if (fe_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_flush_end: got %0d pulses want 0", fe_q.size());
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL reset_mid_count: got %0d ops want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].is_init != exp_q[i].is_init || obs_q[i].line != exp_q[i].line ||
          obs_q[i].way != exp_q[i].way || obs_q[i].cyc != exp_q[i].cyc) begin
        errors++;
        $display("FAIL reset_mid_op %0d: got i=%0d line=%0d way=%0d cyc=%0d want i=%0d line=%0d way=%0d cyc=%0d",
                 i, obs_q[i].is_init, obs_q[i].line, obs_q[i].way, obs_q[i].cyc - base,
                 exp_q[i].is_init, exp_q[i].line, exp_q[i].way, exp_q[i].cyc - base);
      end
    end
    $display("test_reset_mid_flush: %0d ops, %0d flush_end pulses", obs_q.size(), fe_q.size());
  endtask

  initial begin
    test_reset();
    test_flush_basic();
    test_backpressure();
    test_pending();
    test_drain();
    test_reset_mid_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
